// File: rtl/eeg_aram_xbar.sv
// rtl/eeg_aram_xbar.sv - requester-to-ARAM-bank crossbar with per-bank RR arbitration and in-order returns
module eeg_aram_xbar #(
    parameter int  REQ_NUM = 4,
    parameter int  BNK_NUM = 4,
    parameter int  ADD_AW  = 12,
    parameter int  DAT_DW  = 4,
    parameter int  OST_AW  = 2,
    localparam int REQ_AW  = $clog2(REQ_NUM),
    localparam int BNK_AW  = $clog2(BNK_NUM)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REQ_NUM-1:0]               REQ_ADD_VLD,
    input  logic [REQ_NUM-1:0]               REQ_ADD_LST,
    output logic [REQ_NUM-1:0]               REQ_ADD_RDY,
    input  logic [REQ_NUM-1:0][BNK_AW-1:0]   REQ_ADD_BID,
    input  logic [REQ_NUM-1:0][ADD_AW-1:0]   REQ_ADD_ADD,
    output logic [REQ_NUM-1:0]               REQ_DAT_VLD,
    output logic [REQ_NUM-1:0]               REQ_DAT_LST,
    input  logic [REQ_NUM-1:0]               REQ_DAT_RDY,
    output logic [REQ_NUM-1:0][DAT_DW-1:0]   REQ_DAT_DAT,
    output logic [BNK_NUM-1:0]               BNK_ADD_VLD,
    output logic [BNK_NUM-1:0]               BNK_ADD_LST,
    input  logic [BNK_NUM-1:0]               BNK_ADD_RDY,
    output logic [BNK_NUM-1:0][ADD_AW-1:0]   BNK_ADD_ADD,
    input  logic [BNK_NUM-1:0]               BNK_DAT_VLD,
    input  logic [BNK_NUM-1:0]               BNK_DAT_LST,
    output logic [BNK_NUM-1:0]               BNK_DAT_RDY,
    input  logic [BNK_NUM-1:0][DAT_DW-1:0]   BNK_DAT_DAT,
    output logic [BNK_NUM-1:0]               STAT_ERR
);
    localparam int DEPTH = 1 << OST_AW;

    logic [REQ_NUM-1:0][OST_AW:0]             ost_cnt_q, ost_cnt_d;
    logic [REQ_NUM-1:0][BNK_AW-1:0]           last_bid_q, last_bid_d;
    logic [BNK_NUM-1:0][REQ_AW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [BNK_NUM-1:0][REQ_AW-1:0]           lock_id_q, lock_id_d;
    logic [BNK_NUM-1:0]                       lock_q, lock_d;
    logic [BNK_NUM-1:0][DEPTH-1:0][REQ_AW-1:0] tag_mem_q, tag_mem_d;
    logic [BNK_NUM-1:0][OST_AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [BNK_NUM-1:0][OST_AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [BNK_NUM-1:0][OST_AW:0]             tag_cnt_q, tag_cnt_d;
    logic [BNK_NUM-1:0]                       stat_err_q, stat_err_d;

    logic [BNK_NUM-1:0][REQ_NUM-1:0]          elig;
    logic [BNK_NUM-1:0][REQ_AW-1:0]           winner;
    logic [BNK_NUM-1:0]                       grant_valid;
    logic [BNK_NUM-1:0]                       tag_full, tag_empty;
    logic [BNK_NUM-1:0][REQ_AW-1:0]           head;
    logic [BNK_NUM-1:0]                       bnk_add_hs, bnk_dat_hs;
    logic [REQ_NUM-1:0]                       req_add_hs, req_dat_hs;

    assign bnk_add_hs = BNK_ADD_VLD & BNK_ADD_RDY;
    assign bnk_dat_hs = BNK_DAT_VLD & BNK_DAT_RDY;
    assign req_add_hs = REQ_ADD_VLD & REQ_ADD_RDY;
    assign req_dat_hs = REQ_DAT_VLD & REQ_DAT_RDY;
    assign STAT_ERR   = stat_err_q;

    // A requester with returns pending may only keep talking to the same bank, keeping its data in order.
    always_comb begin
        for (int b = 0; b < BNK_NUM; b++) begin
            for (int r = 0; r < REQ_NUM; r++) begin
                elig[b][r] = REQ_ADD_VLD[r] && (REQ_ADD_BID[r] == BNK_AW'(b)) &&
                             ((ost_cnt_q[r] == '0) || (last_bid_q[r] == BNK_AW'(b))) &&
                             !ost_cnt_q[r][OST_AW];
            end
        end
    end

    always_comb begin
        int                tmp;
        logic [REQ_AW-1:0] cand;
        tmp  = 0;
        cand = '0;
        for (int b = 0; b < BNK_NUM; b++) begin
            winner[b]      = '0;
            grant_valid[b] = 1'b0;
            if (lock_q[b]) begin
                winner[b]      = lock_id_q[b];
                grant_valid[b] = elig[b][lock_id_q[b]];
            end else begin
                for (int k = 0; k < REQ_NUM; k++) begin
                    tmp = int'(rr_ptr_q[b]) + k;
                    if (tmp >= REQ_NUM) tmp = tmp - REQ_NUM;
                    cand = REQ_AW'(tmp);
                    if (!grant_valid[b] && elig[b][cand]) begin
                        winner[b]      = cand;
                        grant_valid[b] = 1'b1;
                    end
                end
            end
            grant_valid[b] = grant_valid[b] & rst_n;
        end
    end

    always_comb begin
        for (int b = 0; b < BNK_NUM; b++) begin
            tag_full[b]  = tag_cnt_q[b][OST_AW];
            tag_empty[b] = (tag_cnt_q[b] == '0);
            head[b]      = tag_mem_q[b][rd_ptr_q[b]];
        end
    end

    always_comb begin
        REQ_ADD_RDY = '0;
        REQ_DAT_VLD = '0;
        REQ_DAT_LST = '0;
        REQ_DAT_DAT = '0;
        for (int b = 0; b < BNK_NUM; b++) begin
            BNK_ADD_VLD[b] = grant_valid[b] & ~tag_full[b];
            BNK_ADD_ADD[b] = REQ_ADD_ADD[winner[b]];
            BNK_ADD_LST[b] = REQ_ADD_LST[winner[b]];
            BNK_DAT_RDY[b] = ~tag_empty[b] & REQ_DAT_RDY[head[b]];
            if (grant_valid[b] && !tag_full[b] && BNK_ADD_RDY[b]) begin
                REQ_ADD_RDY[winner[b]] = 1'b1;
            end
            if (!tag_empty[b] && BNK_DAT_VLD[b]) begin
                REQ_DAT_VLD[head[b]] = 1'b1;
                REQ_DAT_LST[head[b]] = BNK_DAT_LST[b];
                REQ_DAT_DAT[head[b]] = BNK_DAT_DAT[b];
            end
        end
    end

    always_comb begin
        ost_cnt_d  = ost_cnt_q;
        last_bid_d = last_bid_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        lock_d     = lock_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tag_cnt_d  = tag_cnt_q;
        stat_err_d = stat_err_q;
        for (int r = 0; r < REQ_NUM; r++) begin
            case ({req_add_hs[r], req_dat_hs[r]})
                2'b10:   ost_cnt_d[r] = ost_cnt_q[r] + 1'b1;
                2'b01:   ost_cnt_d[r] = ost_cnt_q[r] - 1'b1;
                default: ost_cnt_d[r] = ost_cnt_q[r];
            endcase
            if (req_add_hs[r]) last_bid_d[r] = REQ_ADD_BID[r];
        end
        for (int b = 0; b < BNK_NUM; b++) begin
            if (bnk_add_hs[b]) begin
                tag_mem_d[b][wr_ptr_q[b]] = winner[b];
                wr_ptr_d[b] = wr_ptr_q[b] + 1'b1;
                if (BNK_ADD_LST[b]) begin
                    lock_d[b]   = 1'b0;
                    rr_ptr_d[b] = (winner[b] == REQ_AW'(REQ_NUM - 1)) ? '0 : winner[b] + 1'b1;
                end else begin
                    lock_d[b]    = 1'b1;
                    lock_id_d[b] = winner[b];
                end
            end
            if (bnk_dat_hs[b]) rd_ptr_d[b] = rd_ptr_q[b] + 1'b1;
            case ({bnk_add_hs[b], bnk_dat_hs[b]})
                2'b10:   tag_cnt_d[b] = tag_cnt_q[b] + 1'b1;
                2'b01:   tag_cnt_d[b] = tag_cnt_q[b] - 1'b1;
                default: tag_cnt_d[b] = tag_cnt_q[b];
            endcase
            stat_err_d[b] = stat_err_q[b] | (BNK_DAT_VLD[b] & tag_empty[b]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ost_cnt_q  <= '0;
            last_bid_q <= '0;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            lock_q     <= '0;
            tag_mem_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_cnt_q  <= '0;
            stat_err_q <= '0;
        end else begin
            ost_cnt_q  <= ost_cnt_d;
            last_bid_q <= last_bid_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            lock_q     <= lock_d;
            tag_mem_q  <= tag_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_cnt_q  <= tag_cnt_d;
            stat_err_q <= stat_err_d;
        end
    end
endmodule
